// File: rtl/fifo_sdp_ram.sv
// Single-clock FIFO: distributed pseudo-dual-port RAM feeding a registered
// first-word-fall-through output stage. Capacity is the full RAM plus the output register.
module fifo_sdp_ram #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int ALMOST_FULL = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] RAM_FULL  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LEVEL_MAX = (ADDR_WIDTH+1)'(DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] AF_LEVEL  = (ADDR_WIDTH+1)'(ALMOST_FULL);

  // Valid/ready: a word moves on any edge where valid && ready are both high;
  // in_ready depends only on registered occupancy (and reset), never on in_valid or out_ready.

  (* ramstyle = "MLAB, no_rw_check" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  almost_full_q, almost_full_d;
  logic                  push, pop, load;

  assign in_ready    = !reset && (ram_count_q != RAM_FULL);
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign level       = level_q;
  assign almost_full = almost_full_q;

  always_comb begin
    push          = in_valid && in_ready;
    pop           = out_valid_q && out_ready;
    // The RAM is only read when it holds unread data, so rptr never collides with a live write.
    load          = (!out_valid_q || pop) && (ram_count_q != '0);
    wptr_d        = push ? wptr_q + ADDR_WIDTH'(1) : wptr_q;
    rptr_d        = load ? rptr_q + ADDR_WIDTH'(1) : rptr_q;
    ram_count_d   = ram_count_q;
    level_d       = level_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    case ({push, load})
      2'b10:   ram_count_d = ram_count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   ram_count_d = ram_count_q - (ADDR_WIDTH+1)'(1);
      default: ram_count_d = ram_count_q;
    endcase
    case ({push, pop})
      2'b10:   level_d = level_q + (ADDR_WIDTH+1)'(1);
      2'b01:   level_d = level_q - (ADDR_WIDTH+1)'(1);
      default: level_d = level_q;
    endcase
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = mem[rptr_q];
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
    almost_full_d = (level_d >= AF_LEVEL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      ram_count_q   <= '0;
      level_q       <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      almost_full_q <= 1'b0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      ram_count_q   <= ram_count_d;
      level_q       <= level_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      almost_full_q <= almost_full_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wptr_q] <= in_data;
  end

  a_level_max: assert property (@(posedge clock) disable iff (reset) level_q <= LEVEL_MAX);
  a_no_push_full: assert property (@(posedge clock) disable iff (reset) push |-> (ram_count_q != RAM_FULL));
  a_stall_hold: assert property (@(posedge clock) disable iff (reset)
    (out_valid_q && !out_ready) |=> (out_valid_q && $stable(out_data_q)));

endmodule

// File: tb/tb_fifo_sdp_ram.sv
// Bench for fifo_sdp_ram: queue-level reference model checked every cycle, directed
// scenarios plus randomized handshakes, and literal pins on key points.
module tb_fifo_sdp_ram;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [4:0] level;
  logic       almost_full;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_sdp_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALMOST_FULL(12)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .level(level), .almost_full(almost_full)
  );

  // clock / reset
  always #5 clock = ~clock;

  // Reference model: exp_q holds every word in the FIFO in order; m_ov says the
  // head is presented on the output, m_od is the last presented word.
  logic [7:0] exp_q[$];
  bit         m_ov = 1'b0;
  logic [7:0] m_od = 8'h00;
  bit         started = 1'b0;

  function automatic int ram_words();
    return exp_q.size() - (m_ov ? 1 : 0);
  endfunction

  always @(posedge clock) begin
    int  ram_n;
    bit  m_push, m_pop;
    ram_n  = ram_words();
    m_push = in_valid && !reset && (ram_n < 16);
    m_pop  = m_ov && out_ready;
    if (reset) begin
      exp_q.delete();
      m_ov    = 1'b0;
      m_od    = 8'h00;
      started = 1'b1;
    end else if (started) begin
      if (m_pop) void'(exp_q.pop_front());
      if (!m_ov || m_pop) begin
        if (ram_n > 0) begin
          m_ov = 1'b1;
          m_od = exp_q[0];
        end else begin
          m_ov = 1'b0;
        end
      end
      if (m_push) exp_q.push_back(in_data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, away from the active edge.
  always @(negedge clock) begin
    if (started) begin
      check("in_ready",    32'(in_ready),    32'(!reset && (ram_words() < 16)));
      check("out_valid",   32'(out_valid),   32'(m_ov));
      check("out_data",    32'(out_data),    32'(m_od));
      check("level",       32'(level),       32'(exp_q.size()));
      check("almost_full", 32'(almost_full), 32'(exp_q.size() >= 12));
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  initial begin
    int  pushed;
    int  cycles;
    bit  acc;
    logic [7:0] d;

    reset = 1'b1;
    repeat (3) step();
    check("reset_level", 32'(level), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;

    // single word latency
    drive(1'b1, 8'hA5, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0);
    step();
    check("a5_out_valid", 32'(out_valid), 32'd1);
    check("a5_out_data", 32'(out_data), 32'hA5);
    check("a5_level", 32'(level), 32'd1);
    check("a5_almost_full", 32'(almost_full), 32'd0);
    drive(1'b0, 8'h00, 1'b1);
    step();
    check("a5_drained", 32'(level), 32'd0);

    // fill to capacity, 18th offer refused
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 1'b0);
    check("full_level", 32'(level), 32'd17);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_almost_full", 32'(almost_full), 32'd1);
    check("model_full_size", 32'(exp_q.size()), 32'd17);
    check("model_last_word", 32'(exp_q[16]), 32'h10);
    step();

    // drain from full
    drive(1'b0, 8'h00, 1'b1);
    step();
    check("drain_in_ready", 32'(in_ready), 32'd1);
    check("drain_second_word", 32'(out_data), 32'h01);
    repeat (19) step();
    check("drain_level", 32'(level), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    // streaming: 100 incrementing words, continuous pop
    d = 8'h00;
    pushed = 0;
    cycles = 0;
    while (pushed < 100 && cycles < 400) begin
      drive(1'b1, d, 1'b1);
      acc = in_ready;
      step();
      cycles++;
      if (acc) begin
        d++;
        pushed++;
      end
      if (cycles > 2) check("stream_level_1_or_2", 32'(level == 5'd1 || level == 5'd2), 32'd1);
    end
    check("stream_bound", 32'(pushed), 32'd100);
    drive(1'b0, 8'h00, 1'b1);
    repeat (4) step();
    check("stream_drained", 32'(level), 32'd0);

    // random handshakes, 200 words
    pushed = 0;
    cycles = 0;
    while (pushed < 200 && cycles < 3000) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0));
      acc = in_valid && in_ready;
      step();
      cycles++;
      if (acc) pushed++;
    end
    check("random_bound", 32'(pushed), 32'd200);
    drive(1'b0, 8'h00, 1'b1);
    repeat (20) step();
    check("random_drained", 32'(level), 32'd0);

    // reset with 9 words held
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 8'(8'h50 + i), 1'b0);
      step();
    end
    check("hold9_level", 32'(level), 32'd9);
    reset = 1'b1;
    drive(1'b1, 8'hEE, 1'b1);
    step();
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    drive(1'b1, 8'h3C, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0);
    step();
    check("post_rst_out_data", 32'(out_data), 32'h3C);
    check("post_rst_level", 32'(level), 32'd1);
    drive(1'b0, 8'h00, 1'b1);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_sdp_ram.md
Name: fifo_sdp_ram

Overview:
- Single-clock, parametrised FIFO with a ready/valid handshake on both sides.
- Storage is a distributed pseudo-dual-port RAM, 2**ADDR_WIDTH words deep, followed by a registered output stage with first-word-fall-through behaviour.
- It is the buffered, flow-controlled successor to the plain simple-dual-port RAM primitives, used between streaming stages and for clock-enable-free rate smoothing.

Parameters:
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 4: RAM address width; RAM holds 2**ADDR_WIDTH words.
- ALMOST_FULL, 12: level at or above which almost_full asserts; legal range 1..2**ADDR_WIDTH+1.

Ports:
- clock  in  1: single clock; all logic on the rising edge.
- reset  in  1: synchronous, active-high reset.
- in_valid  in  1: producer offers in_data.
- in_ready  out  1: FIFO accepts a word this cycle.
- in_data  in  DATA_WIDTH: write data.
- out_valid  out  1: out_data holds a valid word.
- out_ready  in  1: consumer takes out_data this cycle.
- out_data  out  DATA_WIDTH: head-of-queue word, registered.
- level  out  ADDR_WIDTH+1: words held (RAM words plus output register).
- almost_full  out  1: level >= ALMOST_FULL.

Behaviour:
- Interface decision: one clock (clock); reset is synchronous and active-high (reset).
- Reset state:
  - Write and read pointers = 0; RAM occupancy = 0.
  - out_valid = 0, out_data = 0, level = 0, almost_full = 0.
  - in_ready = 0 while reset is high; in_ready = 1 on the first cycle after reset is released.
  - RAM contents are not cleared.
- Capacity is 2**ADDR_WIDTH + 1 words: the full RAM plus the output register.
- Push: occurs when in_valid && in_ready. The word is written at the write pointer, and the write pointer increments mod 2**ADDR_WIDTH.
- Pop: occurs when out_valid && out_ready.
- in_ready = !ram_full. It is registered or derived from registered state only, with no combinational path from out_ready or in_valid.
- Output stage load: when (!out_valid || pop) && ram_count != 0, the output stage loads memory[rptr] into out_data, sets out_valid = 1, and increments the read pointer.
  - If the output stage frees and the RAM is empty, out_valid goes to 0 and out_data holds its last value.
- Latency:
  - A word pushed into a completely empty FIFO at edge N is in the RAM after N. It loads into out_data at edge N+1, so out_valid is visible in the cycle after N+1.
  - With back-to-back push and pop, throughput is 1 word per clock.
- Read-during-write safety: the RAM is read only when ram_count != 0, so rptr never equals a wptr that is being written with unread data. Reads are therefore never ambiguous. Keep the no_rw_check RAM style.
- level and almost_full:
  - level updates on the same edge as the state change: +1 on push, -1 on pop, unchanged on push+pop.
  - almost_full is registered, consistent with the level value after the same edge.
- Boundary conditions:
  - Full (ram_count == 2**ADDR_WIDTH): in_ready = 0 and pushes are ignored. A simultaneous pop frees a RAM slot via the output load, so in_ready returns to 1 the next cycle.
  - Empty (level == 0): out_valid = 0 and out_ready is ignored.
  - Pointer wrap-around uses an extra MSB or an explicit counter. Full and empty must be distinguishable at equal address bits.
  - Reset mid-operation discards all data. Outputs return to their reset values on the next edge, independent of in_valid and out_ready.
  - out_data and out_valid must not change while out_valid && !out_ready (stall hold).
- FORMAL block:
  - Assert level <= 2**ADDR_WIDTH + 1.
  - Assert no push while full.
  - Assert the stall-hold property.

Test Plan:
- Reset, then push A5 at N -> out_valid = 1 with out_data = A5 after edge N+1; level = 1; almost_full = 0.
- Push 17 words 00..10 with out_ready = 0 -> in_ready drops after the 17th push; level = 17; almost_full high from level 12; an 18th in_valid is not accepted.
- From full, pop continuously -> words emerge 00..10 in order, one per cycle; in_ready = 1 one cycle after the first pop; level reaches 0 and out_valid = 0.
- Continuous push and pop, 100 incrementing words -> no bubbles after the first output; level steady at 1 or 2; data order exact across pointer wrap (more than 16 words).
- Stall: out_ready toggles randomly for 3 cycles while out_valid -> out_data stable during stalls; no loss or duplication over 200 random-handshake words, checked against a reference queue.
- Assert reset with 9 words held -> next cycle: level = 0, out_valid = 0, out_data = 0; a subsequent push of 3C appears as the first output.
